// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register completer.
package apb_slave_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_t;

  localparam int WAIT_W = 4;

  localparam logic [5:0] IDX_ID       = 6'd0;
  localparam logic [5:0] IDX_CTRL     = 6'd1;
  localparam logic [5:0] IDX_XFER_CNT = 6'd2;
  localparam logic [5:0] IDX_SCRATCH0 = 6'd3;

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter for APB wait states; done flags the edge at which
// the count expires so the caller can register PREADY from it.
module apb_wait_ctr
  import apb_slave_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A zero load completes immediately; otherwise expire on the step from 1 to 0.
  assign done = load ? (load_val == '0) : (dec && (count_q == W'(1)));

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with ID/CTRL/XFER_CNT/SCRATCH registers and programmable wait states.
// Optional macro APB_REG_SLAVE_PSLVERR_EN enables PSLVERR on invalid accesses.
//
// state     | meaning
// ST_IDLE   | no transfer in progress, waiting for a setup phase
// ST_ACCESS | access phase, counting wait states until PREADY
module apb_reg_slave
  import apb_slave_pkg::*;
#(
  parameter int          NUM_REGS = 16,
  parameter logic [31:0] ID_VALUE = 32'hA5B0_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  apb_state_t        state_q;
  logic              pready_q;
  logic              pwrite_q;
  logic              err_q;
  logic [5:0]        idx_q;
  logic [31:0]       rdata_q;
  logic [WAIT_W-1:0] ctrl_q;
  logic [15:0]       xfer_cnt_q;
  logic [31:0]       scratch_q [IDX_SCRATCH0:NUM_REGS-1];

  logic [5:0]  idx;
  logic        setup;
  logic        setup_err;
  logic        xfer_done;
  logic        ctr_dec;
  logic        ctr_done;
  logic [31:0] rd_val;
  logic        unused_addr;

  assign idx         = PADDR[7:2];
  assign unused_addr = ^PADDR[31:8];
  assign setup       = (state_q == ST_IDLE) && PSEL && !PENABLE;
  assign ctr_dec     = (state_q == ST_ACCESS) && !pready_q && PSEL;
  assign xfer_done   = (state_q == ST_ACCESS) && pready_q && PSEL && PENABLE;

  assign setup_err = (PADDR[1:0] != 2'b00) || (int'(idx) >= NUM_REGS) ||
                     (PWRITE && ((idx == IDX_ID) || (idx == IDX_XFER_CNT)));

  apb_wait_ctr #(.W(WAIT_W)) u_wait_ctr (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .load     (setup),
    .load_val (ctrl_q),
    .dec      (ctr_dec),
    .done     (ctr_done)
  );

  always_comb begin
    rd_val = '0;
    if (idx == IDX_ID) begin
      rd_val = ID_VALUE;
    end else if (idx == IDX_CTRL) begin
      rd_val = {{(32-WAIT_W){1'b0}}, ctrl_q};
    end else if (idx == IDX_XFER_CNT) begin
      rd_val = {16'h0000, xfer_cnt_q};
    end else begin
      for (int i = int'(IDX_SCRATCH0); i < NUM_REGS; i++) begin
        if (idx == 6'(i)) rd_val = scratch_q[i];
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      pready_q <= 1'b0;
      pwrite_q <= 1'b0;
      err_q    <= 1'b0;
      idx_q    <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (setup) begin
            state_q  <= ST_ACCESS;
            pready_q <= ctr_done;
            pwrite_q <= PWRITE;
            err_q    <= setup_err;
            idx_q    <= idx;
            rdata_q  <= (setup_err || PWRITE) ? 32'h0 : rd_val;
          end
        end
        ST_ACCESS: begin
          if (pready_q || !PSEL) begin
            state_q  <= ST_IDLE;
            pready_q <= 1'b0;
          end else begin
            pready_q <= ctr_done;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ctrl_q     <= '0;
      xfer_cnt_q <= '0;
      for (int i = int'(IDX_SCRATCH0); i < NUM_REGS; i++) scratch_q[i] <= '0;
    end else if (xfer_done) begin
      if (pwrite_q && !err_q) begin
        if (idx_q == IDX_CTRL) begin
          if (PSTRB[0]) ctrl_q <= PWDATA[WAIT_W-1:0];
        end else begin
          for (int i = int'(IDX_SCRATCH0); i < NUM_REGS; i++) begin
            if (idx_q == 6'(i)) begin
              for (int b = 0; b < 4; b++) begin
                if (PSTRB[b]) scratch_q[i][8*b +: 8] <= PWDATA[8*b +: 8];
              end
            end
          end
        end
      end
      if (!PSLVERR) xfer_cnt_q <= xfer_cnt_q + 16'd1;
    end
  end

  assign PREADY = pready_q;
  assign PRDATA = (pready_q && !pwrite_q) ? rdata_q : 32'h0;

`ifdef APB_REG_SLAVE_PSLVERR_EN
  assign PSLVERR = pready_q & err_q;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave against a register-map reference model.
module tb_apb_reg_slave;

  localparam int          N   = 16;
  localparam logic [31:0] IDV = 32'hA5B0_0001;
`ifdef APB_REG_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [3:0]  PSTRB = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checks = 0;
  int failures = 0;

  logic [31:0] m_scr [N];
  logic [3:0]  m_ctrl;
  logic [15:0] m_cnt;

  apb_reg_slave #(.NUM_REGS(N), .ID_VALUE(IDV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_scr[i] = '0;
    m_ctrl = '0;
    m_cnt  = '0;
  endfunction

  // Transfer outcome from the register map rules; updates the model state.
  function automatic void model_xfer(input bit wr, input logic [31:0] addr,
                                     input logic [31:0] data, input logic [3:0] strb,
                                     output logic [31:0] rd, output bit err, output int waits);
    int idx;
    bit bad;
    idx   = int'(addr[7:2]);
    bad   = (addr[1:0] != 2'b00) || (idx >= N) || (wr && (idx == 0 || idx == 2));
    waits = int'(m_ctrl) + 1;
    err   = bad && ERR_EN;
    rd    = '0;
    if (!wr && !bad) begin
      case (idx)
        0:       rd = IDV;
        1:       rd = {28'h0, m_ctrl};
        2:       rd = {16'h0, m_cnt};
        default: rd = m_scr[idx];
      endcase
    end
    if (wr && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) begin
          if (idx == 1 && b == 0) m_ctrl = data[3:0];
          else if (idx >= 3)      m_scr[idx][8*b +: 8] = data[8*b +: 8];
        end
      end
    end
    if (!err) m_cnt = m_cnt + 16'd1;
  endfunction

  // Called at a negedge; returns at the negedge after completion with PSEL low.
  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rd, output bit err,
                          output int waits);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(negedge HCLK);
    PENABLE = 1'b1;
    waits = 1;
    while (!PREADY && waits < 40) begin
      @(negedge HCLK);
      waits++;
    end
    rd  = PRDATA;
    err = PSLVERR;
    if (!PREADY) begin
      checks++; failures++;
      $display("FAIL xfer_timeout addr=%h no PREADY after %0d cycles", addr, waits);
    end
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    model_reset();
    repeat (3) @(negedge HCLK);
    checks++;
    if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs got ready=%b err=%b rdata=%h exp 0/0/0", PREADY, PSLVERR, PRDATA);
    end
    HRESETn = 1'b1;
    @(negedge HCLK);
  endtask

  task automatic test_id_read();
    logic [31:0] rd, erd; bit er, eer; int w, ew;
    model_xfer(1'b0, 32'h0, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'h0, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (w !== 1) begin failures++; $display("FAIL id_wait got %0d exp 1", w); end
    checks++;
    if (rd !== 32'hA5B0_0001) begin failures++; $display("FAIL id_rdata got %h exp a5b00001", rd); end
    checks++;
    if (er !== 1'b0) begin failures++; $display("FAIL id_err got %b exp 0", er); end
  endtask

  task automatic test_wait_write();
    logic [31:0] rd, erd; bit er, eer; int w, ew;
    model_xfer(1'b1, 32'h4, 32'h3, 4'hF, erd, eer, ew);
    apb_xfer(1'b1, 32'h4, 32'h3, 4'hF, rd, er, w);
    model_xfer(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, erd, eer, ew);
    apb_xfer(1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF, rd, er, w);
    checks++;
    if (w !== 4) begin failures++; $display("FAIL wait3_cycles got %0d exp 4", w); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL write_rdata got %h exp 0", rd); end
    model_xfer(1'b0, 32'hC, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL scratch_rb got %h exp deadbeef", rd); end
    checks++;
    if (PREADY !== 1'b0) begin failures++; $display("FAIL ready_drop got %b exp 0", PREADY); end
    model_xfer(1'b0, 32'h8, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL xfer_cnt got %h exp %h", rd, erd); end
  endtask

  task automatic test_strobes();
    logic [31:0] rd, erd; bit er, eer; int w, ew;
    model_xfer(1'b1, 32'h4, 32'h0, 4'h1, erd, eer, ew);
    apb_xfer(1'b1, 32'h4, 32'h0, 4'h1, rd, er, w);
    model_xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, erd, eer, ew);
    apb_xfer(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd, er, w);
    model_xfer(1'b1, 32'h10, 32'h1234_5678, 4'b0101, erd, eer, ew);
    apb_xfer(1'b1, 32'h10, 32'h1234_5678, 4'b0101, rd, er, w);
    apb_xfer(1'b0, 32'h10, 32'h0, 4'h0, rd, er, w);
    model_xfer(1'b0, 32'h10, 32'h0, 4'h0, erd, eer, ew);
    checks++;
    if (rd !== 32'hFF34_FF78) begin failures++; $display("FAIL strobe_rb got %h exp ff34ff78", rd); end
    checks++;
    if (w !== 1) begin failures++; $display("FAIL wait0_cycles got %0d exp 1", w); end
  endtask

  task automatic test_invalid();
    logic [31:0] rd, c0, erd; bit er, eer; int w, ew;
    logic [31:0] addrs [4];
    bit          wrs   [4];
    addrs[0] = 32'h8;  wrs[0] = 1'b1;
    addrs[1] = 32'h2;  wrs[1] = 1'b0;
    addrs[2] = 32'h40; wrs[2] = 1'b0;
    addrs[3] = 32'h0;  wrs[3] = 1'b1;
    model_xfer(1'b0, 32'h8, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, c0, er, w);
    for (int k = 0; k < 4; k++) begin
      model_xfer(wrs[k], addrs[k], 32'h1, 4'hF, erd, eer, ew);
      apb_xfer(wrs[k], addrs[k], 32'h1, 4'hF, rd, er, w);
      checks++;
      if (er !== ERR_EN) begin failures++; $display("FAIL inv_err addr=%h got %b exp %b", addrs[k], er, ERR_EN); end
      checks++;
      if (rd !== 32'h0) begin failures++; $display("FAIL inv_rdata addr=%h got %h exp 0", addrs[k], rd); end
    end
    model_xfer(1'b0, 32'h8, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== c0 + (ERR_EN ? 32'd1 : 32'd5)) begin
      failures++; $display("FAIL inv_cnt got %h exp %h", rd, c0 + (ERR_EN ? 32'd1 : 32'd5));
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, data; bit er, eer, wr; int w, ew, kind;
    logic [5:0] ix; logic [1:0] lo; logic [3:0] strb;
    for (int t = 0; t < 80; t++) begin
      kind = int'($urandom_range(0, 9));
      wr   = 1'($urandom_range(0, 1));
      data = $urandom;
      strb = 4'($urandom);
      lo   = 2'b00;
      if (kind == 0) begin
        ix = 6'($urandom_range(0, N-1)); lo = 2'($urandom_range(1, 3));
      end else if (kind == 1) begin
        ix = 6'($urandom_range(N, 63));
      end else begin
        ix = 6'($urandom_range(0, N-1));
      end
      if (ix == 6'd1) data = data & ~32'hC;
      addr = {24'($urandom), ix, lo};
      model_xfer(wr, addr, data, strb, erd, eer, ew);
      apb_xfer(wr, addr, data, strb, rd, er, w);
      checks++;
      if (w !== ew) begin failures++; $display("FAIL rnd_wait t=%0d addr=%h got %0d exp %0d", t, addr, w, ew); end
      checks++;
      if (rd !== erd) begin failures++; $display("FAIL rnd_rdata t=%0d addr=%h got %h exp %h", t, addr, rd, erd); end
      checks++;
      if (er !== eer) begin failures++; $display("FAIL rnd_err t=%0d addr=%h got %b exp %b", t, addr, er, eer); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd, erd; bit er, eer; int w, ew;
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'hFFFD; exp_seq[1] = 32'hFFFE; exp_seq[2] = 32'hFFFF; exp_seq[3] = 32'h0000;
    force dut.xfer_cnt_q = 16'hFFFD;
    @(negedge HCLK);
    release dut.xfer_cnt_q;
    m_cnt = 16'hFFFD;
    @(negedge HCLK);
    for (int k = 0; k < 4; k++) begin
      model_xfer(1'b0, 32'h8, 32'h0, 4'h0, erd, eer, ew);
      apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, w);
      checks++;
      if (rd !== exp_seq[k]) begin failures++; $display("FAIL cnt_wrap k=%0d got %h exp %h", k, rd, exp_seq[k]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; bit er, eer; int w, ew, seen;
    model_xfer(1'b1, 32'h4, 32'h5, 4'h1, erd, eer, ew);
    apb_xfer(1'b1, 32'h4, 32'h5, 4'h1, rd, er, w);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'h0BAD_F00D; PSTRB = 4'hF;
    @(negedge HCLK);
    PENABLE = 1'b1;
    checks++;
    if (PREADY !== 1'b0) begin failures++; $display("FAIL abort_c1_ready got %b exp 0", PREADY); end
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge HCLK);
      if (PREADY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_ready got %0d ready cycles exp 0", seen); end
    model_xfer(1'b0, 32'hC, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'hC, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL abort_data got %h exp %h", rd, erd); end
    checks++;
    if (w !== 6) begin failures++; $display("FAIL abort_wait got %0d exp 6", w); end
    model_xfer(1'b0, 32'h8, 32'h0, 4'h0, erd, eer, ew);
    apb_xfer(1'b0, 32'h8, 32'h0, 4'h0, rd, er, w);
    checks++;
    if (rd !== erd) begin failures++; $display("FAIL abort_cnt got %h exp %h", rd, erd); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; bit er, eer; int w, ew;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'hCAFE_0000; PSTRB = 4'hF;
    @(negedge HCLK);
    PENABLE = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    checks++;
    if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
      failures++; $display("FAIL midrst_outputs got ready=%b err=%b rdata=%h exp 0/0/0", PREADY, PSLVERR, PRDATA);
    end
    model_reset();
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    HRESETn = 1'b1;
    @(negedge HCLK);
    for (int i = 1; i < N; i++) begin
      model_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, erd, eer, ew);
      apb_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er, w);
      checks++;
      if (rd !== erd || w !== 1) begin
        failures++; $display("FAIL midrst_reg idx=%0d got %h/%0d exp %h/1", i, rd, w, erd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_wait_write();
    test_strobes();
    test_invalid();
    test_random();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
